// File: rtl/mux_scan_pkg.sv
// Shared types and width helpers for the N-channel scanning multiplexer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mux_scan_pkg;

  typedef enum logic {MANUAL, SCAN} scan_state_t;

  // Bit width needed to count 0..n-1. Never returns 0, so a
  // single-state counter still has a real 1-bit register behind it.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_scan_pointer.sv
// Channel pointer and dwell counter for auto-scan; emits a wrap pulse on N_CH-1 -> 0.
// Latency: 1 cycle from load/step to cur_sel_o; nxt_sel_o is the combinational next value.
// Backpressure: none; en_i freezes all state and forces wrap_o low, hold_i freezes stepping only.
module mux_scan_pointer
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DWELL = 4,
  localparam int SELW = clog2_min1(N_CH),
  localparam int CW   = clog2_min1(DWELL)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [SELW-1:0] load_val_i,
  input  logic            clr_i,
  input  logic            step_i,
  input  logic            hold_i,
  output logic [SELW-1:0] cur_sel_o,
  output logic [SELW-1:0] nxt_sel_o,
  output logic            wrap_o
);

  // Wrap at N_CH-1 is explicit: for non-power-of-two N_CH natural
  // overflow of the select register would visit illegal channels.
  localparam logic [SELW-1:0] LAST_SEL   = SELW'(N_CH - 1);
  localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);

  logic [SELW-1:0] sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrap_q, wrap_d;

  // Next pointer/counter: load beats clear beats step; hold only gates stepping.
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load_i) begin
      sel_d = load_val_i;
      cnt_d = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (step_i && !hold_i) begin
      if (cnt_q == DWELL_LAST) begin
        cnt_d = '0;
        if (sel_q == LAST_SEL) begin
          sel_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State update; a disabled cycle freezes pointer and counter but drops wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (en_i) begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign cur_sel_o = sel_q;
  assign nxt_sel_o = sel_d;
  assign wrap_o    = wrap_q;

endmodule

// File: rtl/mux_scan_n.sv
// N-channel WIDTH-bit mux with registered output; manual select or round-robin auto-scan.
// Latency: 1 cycle, y reflects d and the selection sampled at the previous enabled edge.
// Backpressure: none; en=0 freezes all state, hold pauses the scan pointer but not the data.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 1,
  parameter int DWELL = 4,
  localparam int SELW = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] d,
  input  logic [SELW-1:0]       sel,
  input  logic                  mode,
  input  logic                  hold,
  input  logic                  en,
  output logic [WIDTH-1:0]      y,
  output logic [SELW-1:0]       cur_sel,
  output logic                  y_valid,
  output logic                  wrap
);

  // One extra bit so the legality compare also works when N_CH == 2**SELW.
  localparam logic [SELW:0] NCH_W = (SELW + 1)'(N_CH);

  scan_state_t     state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic            y_valid_q, y_valid_d;

  logic            sel_legal;
  logic            ptr_load, ptr_clr, ptr_step;
  logic [SELW-1:0] ptr_load_val;
  logic [SELW-1:0] ptr_cur, ptr_nxt;
  logic            ptr_wrap;
  logic [WIDTH-1:0] nxt_data;

  assign sel_legal = ({1'b0, sel} < NCH_W);

  // Mode decode: manual loads a legal sel, scan entry loads sel or 0, scan steps.
  always_comb begin
    state_d      = mode ? SCAN : MANUAL;
    ptr_load     = 1'b0;
    ptr_clr      = 1'b0;
    ptr_step     = 1'b0;
    ptr_load_val = sel;
    if (!mode) begin
      if (sel_legal) ptr_load = 1'b1;
      else           ptr_clr  = 1'b1;
    end else if (state_q == MANUAL) begin
      ptr_load     = 1'b1;
      ptr_load_val = sel_legal ? sel : '0;
    end else begin
      ptr_step = 1'b1;
    end
  end

  // Channel select on the pointer's next value so y and cur_sel stay aligned.
  always_comb begin
    nxt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ptr_nxt == SELW'(k)) nxt_data = d[k*WIDTH +: WIDTH];
    end
  end

  // Output next-state: an illegal manual select blanks y and drops valid.
  always_comb begin
    y_d       = nxt_data;
    y_valid_d = 1'b1;
    if (!mode && !sel_legal) begin
      y_d       = '0;
      y_valid_d = 1'b0;
    end
  end

  // State and output registers; reset wins over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MANUAL;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  mux_scan_pointer #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_pointer (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .load_i     (ptr_load),
    .load_val_i (ptr_load_val),
    .clr_i      (ptr_clr),
    .step_i     (ptr_step),
    .hold_i     (hold),
    .cur_sel_o  (ptr_cur),
    .nxt_sel_o  (ptr_nxt),
    .wrap_o     (ptr_wrap)
  );

  assign y       = y_q;
  assign cur_sel = ptr_cur;
  assign y_valid = y_valid_q;
  assign wrap    = ptr_wrap;

endmodule
